matrix_display_seq: RTL and testbench

//   Display sequencer downstream of the UART-loaded matrix memory. On start it

---
 rtl/matrix_display_seq_if.sv | 32 +++
 rtl/matrix_display_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_matrix_display_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_display_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_display_seq_if
//  Description : Read bus between the display sequencer and the matrix memory.
//                The sequencer drives the master modport (read strobe and
//                address). The memory drives the slave modport (read data).
//  Signals     : rd_en    - read strobe, one cycle per element
//                rd_addr  - element address, zero-extended
//                rd_data  - element byte, valid MEM_LAT cycles after rd_en
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_display_seq_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/matrix_display_seq.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_display_seq
//  Description : Walks a ROWS x COLS matrix in row-major order. For each
//                element it issues one memory read and waits MEM_LAT cycles.
//                It then captures the byte and shows it as three BCD digits
//                for HOLD_TICKS cycles. The design runs entirely in the
//                slow_clk domain, and every output is registered.
//  Ports       : slow_clk  - display clock, rising edge
//                rst       - asynchronous active-high reset
//                start     - level request for one display pass
//                mem       - read bus (master): rd_en, rd_addr, rd_data
//                bcd_hun/bcd_ten/bcd_one - digits of the displayed element
//                elem_idx  - index of the displayed element
//                valid     - digits hold a captured element
//                busy      - pass in progress
//                done      - pass complete, held until start drops
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_display_seq #(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int MEM_LAT    = 1,
    parameter int HOLD_TICKS = 2
) (
    input  wire logic               slow_clk,
    input  wire logic               rst,
    input  wire logic               start,
    matrix_display_seq_if.master    mem,
    output logic [3:0]              bcd_hun,
    output logic [3:0]              bcd_ten,
    output logic [3:0]              bcd_one,
    output logic [ADDR_W-1:0]       elem_idx,
    output logic                    valid,
    output logic                    busy,
    output logic                    done
);

    localparam int c_N       = ROWS * COLS;
    localparam int c_CNT_MAX = (MEM_LAT > HOLD_TICKS) ? MEM_LAT : HOLD_TICKS;
    // The counter runs 0..c_CNT_MAX-1.
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [ADDR_W-1:0]  c_LAST_IDX  = ADDR_W'(c_N - 1);
    localparam logic [c_CNT_W-1:0] c_LAT_LAST  = c_CNT_W'(MEM_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_TICKS - 1);

    // Capture is not a separate state. It happens on the edge that leaves
    // WAIT, so each element takes READ(1) + WAIT(MEM_LAT) + HOLD(HOLD_TICKS)
    // cycles.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   w_idx_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_rd_en;
    logic                w_rd_en_nxt;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   w_rd_addr_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_capture;
    logic [3:0]          r_bcd_hun;
    logic [3:0]          r_bcd_ten;
    logic [3:0]          r_bcd_one;
    logic [ADDR_W-1:0]   r_elem_idx;
    logic [11:0]         w_bcd;

    // ------------------------------------------------------------------
    // Binary to BCD conversion (double-dabble) of the incoming read data.
    // The result is only registered on the capture edge.
    // ------------------------------------------------------------------
    always_comb begin : p_bcd
        logic [11:0] w_acc;
        w_acc = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (w_acc[3:0]  > 4'd4) w_acc[3:0]  = w_acc[3:0]  + 4'd3;
            if (w_acc[7:4]  > 4'd4) w_acc[7:4]  = w_acc[7:4]  + 4'd3;
            if (w_acc[11:8] > 4'd4) w_acc[11:8] = w_acc[11:8] + 4'd3;
            w_acc = {w_acc[10:0], mem.rd_data[i]};
        end
        w_bcd = w_acc;
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        w_valid_nxt   = r_valid;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_capture     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_READ;
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = '0;
                    w_busy_nxt    = 1'b1;
                    w_valid_nxt   = 1'b0;
                end
            end

            ST_READ: begin
                // The strobe was raised on entry and drops after one cycle.
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = '0;
            end

            ST_WAIT: begin
                if (r_cnt == c_LAT_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_capture   = 1'b1;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_READ;
                        w_idx_nxt     = r_idx + 1'b1;
                        w_rd_en_nxt   = 1'b1;
                        w_rd_addr_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_DONE: begin
                // A new pass needs start to go low first. The digits stay
                // on display through IDLE.
                if (!start) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd_hun  <= 4'd0;
            r_bcd_ten  <= 4'd0;
            r_bcd_one  <= 4'd0;
            r_elem_idx <= '0;
        end else begin
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            if (w_capture) begin
                r_bcd_hun  <= w_bcd[11:8];
                r_bcd_ten  <= w_bcd[7:4];
                r_bcd_one  <= w_bcd[3:0];
                r_elem_idx <= r_idx;
            end
        end
    end

    assign mem.rd_en   = r_rd_en;
    assign mem.rd_addr = r_rd_addr;
    assign bcd_hun     = r_bcd_hun;
    assign bcd_ten     = r_bcd_ten;
    assign bcd_one     = r_bcd_one;
    assign elem_idx    = r_elem_idx;
    assign valid       = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_display_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_display_seq
//  Description : Directed self-checking bench for matrix_display_seq.
//                dut_a : 2x2, MEM_LAT=1, HOLD_TICKS=2
//                dut_b : 2x2, MEM_LAT=3, HOLD_TICKS=2
//                dut_c : 3x3, MEM_LAT=1, HOLD_TICKS=2
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_display_seq;

    logic slow_clk = 1'b0;
    logic rst      = 1'b1;
    logic start_a  = 1'b0;
    logic start_b  = 1'b0;
    logic start_c  = 1'b0;

    logic [3:0] hun_a, ten_a, one_a, hun_b, ten_b, one_b, hun_c, ten_c, one_c;
    logic [5:0] idx_a, idx_b, idx_c;
    logic       valid_a, busy_a, done_a;
    logic       valid_b, busy_b, done_b;
    logic       valid_c, busy_c, done_c;

    int checks = 0;
    int errors = 0;

    // Driven whenever no read result is due. It stands in for undefined data.
    localparam logic [7:0] c_POISON = 8'hEE;

    always #5 slow_clk = ~slow_clk;

    matrix_display_seq_if #(.ADDR_W(6), .DATA_W(8)) if_a ();
    matrix_display_seq_if #(.ADDR_W(6), .DATA_W(8)) if_b ();
    matrix_display_seq_if #(.ADDR_W(6), .DATA_W(8)) if_c ();

    matrix_display_seq #(.ROWS(2), .COLS(2), .DATA_W(8), .ADDR_W(6), .MEM_LAT(1), .HOLD_TICKS(2)) dut_a (
        .slow_clk(slow_clk), .rst(rst), .start(start_a), .mem(if_a),
        .bcd_hun(hun_a), .bcd_ten(ten_a), .bcd_one(one_a), .elem_idx(idx_a),
        .valid(valid_a), .busy(busy_a), .done(done_a));

    matrix_display_seq #(.ROWS(2), .COLS(2), .DATA_W(8), .ADDR_W(6), .MEM_LAT(3), .HOLD_TICKS(2)) dut_b (
        .slow_clk(slow_clk), .rst(rst), .start(start_b), .mem(if_b),
        .bcd_hun(hun_b), .bcd_ten(ten_b), .bcd_one(one_b), .elem_idx(idx_b),
        .valid(valid_b), .busy(busy_b), .done(done_b));

    matrix_display_seq #(.ROWS(3), .COLS(3), .DATA_W(8), .ADDR_W(6), .MEM_LAT(1), .HOLD_TICKS(2)) dut_c (
        .slow_clk(slow_clk), .rst(rst), .start(start_c), .mem(if_c),
        .bcd_hun(hun_c), .bcd_ten(ten_c), .bcd_one(one_c), .elem_idx(idx_c),
        .valid(valid_c), .busy(busy_c), .done(done_c));

    // Memory models: read data appears MEM_LAT edges after the strobe is sampled.
    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];
    logic [7:0] mem_c [64];
    logic       pa_v, pc_v;
    logic [5:0] pa_addr, pc_addr;
    logic [2:0] pb_v;
    logic [5:0] pb_addr [3];

    always @(posedge slow_clk) begin
        pa_v       <= if_a.rd_en;
        pa_addr    <= if_a.rd_addr;
        pc_v       <= if_c.rd_en;
        pc_addr    <= if_c.rd_addr;
        pb_v       <= {pb_v[1:0], if_b.rd_en};
        pb_addr[0] <= if_b.rd_addr;
        pb_addr[1] <= pb_addr[0];
        pb_addr[2] <= pb_addr[1];
    end

    assign if_a.rd_data = (pa_v === 1'b1)    ? mem_a[pa_addr]    : c_POISON;
    assign if_b.rd_data = (pb_v[2] === 1'b1) ? mem_b[pb_addr[2]] : c_POISON;
    assign if_c.rd_data = (pc_v === 1'b1)    ? mem_c[pc_addr]    : c_POISON;

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge slow_clk);
        @(negedge slow_clk);
        checks++;
        if (if_a.rd_en !== 1'b0 || if_a.rd_addr !== 6'd0) begin
            errors++; $display("FAIL reset_rd got en=%b addr=%0d exp en=0 addr=0", if_a.rd_en, if_a.rd_addr);
        end
        checks++;
        if ({hun_a, ten_a, one_a} !== 12'h000 || idx_a !== 6'd0) begin
            errors++; $display("FAIL reset_digits got %h idx=%0d exp 000 idx=0", {hun_a, ten_a, one_a}, idx_a);
        end
        checks++;
        if ({valid_a, busy_a, done_a} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {valid_a, busy_a, done_a});
        end
        checks++;
        if ({busy_b, done_b, busy_c, done_c} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags_bc got %b exp 0000", {busy_b, done_b, busy_c, done_c});
        end
        rst = 1'b0;
        @(negedge slow_clk);
        checks++;
        if (if_a.rd_en !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL idle_no_start got en=%b busy=%b exp 0 0", if_a.rd_en, busy_a);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic_pass();
        logic [11:0] exp_d [4];
        int k, ph;
        exp_d = '{12'h007, 12'h042, 12'h255, 12'h000};
        mem_a[0] = 8'h07; mem_a[1] = 8'h2A; mem_a[2] = 8'hFF; mem_a[3] = 8'h00;
        start_a = 1'b1;
        for (int j = 0; j <= 16; j++) begin
            @(negedge slow_clk);
            k = j / 4; ph = j % 4;
            if (j < 16) begin
                checks++;
                if (if_a.rd_en !== (ph == 0) || (ph == 0 && if_a.rd_addr !== 6'(k))) begin
                    errors++; $display("FAIL basic_rd j=%0d got en=%b addr=%0d exp en=%0d addr=%0d", j, if_a.rd_en, if_a.rd_addr, ph == 0, k);
                end
                checks++;
                if ({busy_a, done_a} !== 2'b10) begin
                    errors++; $display("FAIL basic_busy j=%0d got busy/done=%b exp 10", j, {busy_a, done_a});
                end
                if (ph >= 2) begin
                    checks++;
                    if ({hun_a, ten_a, one_a} !== exp_d[k] || idx_a !== 6'(k) || valid_a !== 1'b1) begin
                        errors++; $display("FAIL basic_digits j=%0d got %h idx=%0d v=%b exp %h idx=%0d v=1", j, {hun_a, ten_a, one_a}, idx_a, valid_a, exp_d[k], k);
                    end
                end else if (k == 0) begin
                    checks++;
                    if (valid_a !== 1'b0) begin
                        errors++; $display("FAIL basic_valid_early j=%0d got %b exp 0", j, valid_a);
                    end
                end
            end else begin
                checks++;
                if ({busy_a, done_a, valid_a, if_a.rd_en} !== 4'b0110 || {hun_a, ten_a, one_a} !== 12'h000 || idx_a !== 6'd3) begin
                    errors++; $display("FAIL basic_done got b/d/v/en=%b digits=%h idx=%0d exp 0110 000 3", {busy_a, done_a, valid_a, if_a.rd_en}, {hun_a, ten_a, one_a}, idx_a);
                end
            end
            if (j == 0) start_a = 1'b0;
        end
        @(negedge slow_clk);
        checks++;
        if ({done_a, valid_a} !== 2'b01) begin
            errors++; $display("FAIL basic_idle got done/valid=%b exp 01", {done_a, valid_a});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mem_latency();
        logic [11:0] exp_d [4];
        int k, ph;
        exp_d = '{12'h099, 12'h100, 12'h005, 12'h250};
        mem_b[0] = 8'd99; mem_b[1] = 8'd100; mem_b[2] = 8'd5; mem_b[3] = 8'd250;
        start_b = 1'b1;
        for (int j = 0; j <= 24; j++) begin
            @(negedge slow_clk);
            k = j / 6; ph = j % 6;
            if (j < 24) begin
                checks++;
                if (if_b.rd_en !== (ph == 0) || (ph == 0 && if_b.rd_addr !== 6'(k))) begin
                    errors++; $display("FAIL lat_rd j=%0d got en=%b addr=%0d exp en=%0d addr=%0d", j, if_b.rd_en, if_b.rd_addr, ph == 0, k);
                end
                checks++;
                if (ph >= 4) begin
                    if ({hun_b, ten_b, one_b} !== exp_d[k] || valid_b !== 1'b1 || idx_b !== 6'(k)) begin
                        errors++; $display("FAIL lat_digits j=%0d got %h v=%b idx=%0d exp %h v=1 idx=%0d", j, {hun_b, ten_b, one_b}, valid_b, idx_b, exp_d[k], k);
                    end
                end else if (k == 0) begin
                    if ({hun_b, ten_b, one_b} !== 12'h000 || valid_b !== 1'b0) begin
                        errors++; $display("FAIL lat_early j=%0d got %h v=%b exp 000 v=0", j, {hun_b, ten_b, one_b}, valid_b);
                    end
                end else begin
                    if ({hun_b, ten_b, one_b} !== exp_d[k-1]) begin
                        errors++; $display("FAIL lat_held j=%0d got %h exp %h", j, {hun_b, ten_b, one_b}, exp_d[k-1]);
                    end
                end
            end else begin
                checks++;
                if ({busy_b, done_b} !== 2'b01 || {hun_b, ten_b, one_b} !== 12'h250) begin
                    errors++; $display("FAIL lat_done got b/d=%b digits=%h exp 01 250", {busy_b, done_b}, {hun_b, ten_b, one_b});
                end
            end
            if (j == 0) start_b = 1'b0;
        end
        @(negedge slow_clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_no_rerun();
        int n_done;
        n_done = 0;
        start_a = 1'b1;
        for (int n = 1; n <= 40 && n_done == 0; n++) begin
            @(negedge slow_clk);
            if (done_a === 1'b1) n_done = n;
        end
        checks++;
        if (n_done != 17) begin
            errors++; $display("FAIL rerun_first_done got edge=%0d exp 17 (0 = timeout)", n_done);
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge slow_clk);
            checks++;
            if ({if_a.rd_en, busy_a, done_a} !== 3'b001) begin
                errors++; $display("FAIL rerun_hold n=%0d got en/busy/done=%b exp 001", n, {if_a.rd_en, busy_a, done_a});
            end
        end
        start_a = 1'b0;
        @(negedge slow_clk);
        checks++;
        if (done_a !== 1'b0) begin
            errors++; $display("FAIL rerun_done_clear got %b exp 0", done_a);
        end
        start_a = 1'b1;
        @(negedge slow_clk);
        checks++;
        if ({if_a.rd_en, busy_a, valid_a} !== 3'b110 || if_a.rd_addr !== 6'd0) begin
            errors++; $display("FAIL rerun_second got en/busy/valid=%b addr=%0d exp 110 0", {if_a.rd_en, busy_a, valid_a}, if_a.rd_addr);
        end
    endtask

    // ------------------------------------------------------------------
    // Continues the second pass started by test_no_rerun (now after e0).
    task automatic test_reset_mid_pass();
        for (int j = 1; j <= 10; j++) @(negedge slow_clk);
        checks++;
        if ({hun_a, ten_a, one_a} !== 12'h255 || idx_a !== 6'd2 || valid_a !== 1'b1) begin
            errors++; $display("FAIL mid_hold2 got %h idx=%0d v=%b exp 255 idx=2 v=1", {hun_a, ten_a, one_a}, idx_a, valid_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({hun_a, ten_a, one_a} !== 12'h000 || idx_a !== 6'd0 || {valid_a, busy_a, done_a, if_a.rd_en} !== 4'b0000) begin
            errors++; $display("FAIL mid_async_reset got %h idx=%0d v/b/d/en=%b exp 000 0 0000", {hun_a, ten_a, one_a}, idx_a, {valid_a, busy_a, done_a, if_a.rd_en});
        end
        @(negedge slow_clk);
        start_a = 1'b0;
        rst = 1'b0;
        @(negedge slow_clk);
        start_a = 1'b1;
        @(negedge slow_clk);
        checks++;
        if (if_a.rd_en !== 1'b1 || if_a.rd_addr !== 6'd0) begin
            errors++; $display("FAIL mid_restart got en=%b addr=%0d exp 1 0", if_a.rd_en, if_a.rd_addr);
        end
        // Reset during the READ cycle must drop the strobe at once.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (if_a.rd_en !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL mid_read_reset got en=%b busy=%b exp 0 0", if_a.rd_en, busy_a);
        end
        start_a = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_start_at_release();
        int n_done;
        @(negedge slow_clk);
        rst = 1'b0;
        start_a = 1'b1;
        #1;
        checks++;
        if (if_a.rd_en !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL release_before_edge got en=%b busy=%b exp 0 0", if_a.rd_en, busy_a);
        end
        @(negedge slow_clk);
        checks++;
        if (if_a.rd_en !== 1'b1 || if_a.rd_addr !== 6'd0 || busy_a !== 1'b1) begin
            errors++; $display("FAIL release_first_read got en=%b addr=%0d busy=%b exp 1 0 1", if_a.rd_en, if_a.rd_addr, busy_a);
        end
        start_a = 1'b0;
        n_done = 0;
        for (int n = 1; n <= 30 && n_done == 0; n++) begin
            @(negedge slow_clk);
            if (done_a === 1'b1) n_done = n;
        end
        checks++;
        if (n_done != 16) begin
            errors++; $display("FAIL release_done got edge=%0d exp 16 (0 = timeout)", n_done);
        end
        @(negedge slow_clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_grid_3x3();
        int k, ph, v, reads;
        logic [11:0] exp_d;
        reads = 0;
        for (int i = 0; i < 9; i++) mem_c[i] = 8'(i * 30);
        start_c = 1'b1;
        for (int j = 0; j <= 36; j++) begin
            @(negedge slow_clk);
            k = j / 4; ph = j % 4;
            if (if_c.rd_en === 1'b1) reads++;
            if (j < 36 && ph == 0) begin
                checks++;
                if (if_c.rd_en !== 1'b1 || if_c.rd_addr !== 6'(k)) begin
                    errors++; $display("FAIL grid_rd j=%0d got en=%b addr=%0d exp 1 %0d", j, if_c.rd_en, if_c.rd_addr, k);
                end
            end
            if (j < 36 && ph == 2) begin
                v = k * 30;
                exp_d = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
                checks++;
                if ({hun_c, ten_c, one_c} !== exp_d || idx_c !== 6'(k) || valid_c !== 1'b1) begin
                    errors++; $display("FAIL grid_digits k=%0d got %h idx=%0d v=%b exp %h", k, {hun_c, ten_c, one_c}, idx_c, valid_c, exp_d);
                end
            end
            if (j == 35 || j == 36) begin
                checks++;
                if (done_c !== (j == 36) || busy_c !== (j == 35)) begin
                    errors++; $display("FAIL grid_done j=%0d got done=%b busy=%b exp done=%0d", j, done_c, busy_c, j == 36);
                end
            end
            if (j == 0) start_c = 1'b0;
        end
        checks++;
        if (reads != 9) begin
            errors++; $display("FAIL grid_reads got %0d exp 9", reads);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_mem_latency();
        test_no_rerun();
        test_reset_mid_pass();
        test_start_at_release();
        test_grid_3x3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
